integral_window_reader: RTL and testbench
=========================================

Name: integral_window_reader

Overview:
- Read-side counterpart of the integral-image window FIFO. Drains one window of INTEGRAL_WIDTH*INTEGRAL_HEIGHT 12-bit integral values per burst from the FIFO and reassembles them into a parallel window.
- Presents the window to the second-stage classifier compute logic on a valid/ready handshake.
- Sits between the FIFO q/usedw/rdreq port and the classifier datapath.

Parameters:
- ADDR_WIDTH, 10: FIFO usedw width.
- DATA_WIDTH_12, 12: integral value width.
- INTEGRAL_WIDTH, 3: window columns.
- INTEGRAL_HEIGHT, 3: window rows.
- WINDOW_SIZE, INTEGRAL_WIDTH*INTEGRAL_HEIGHT: words per window (derived, not overridden).

Ports:
- clk_fpga  input  1  single clock, rising edge.
- reset_fpga  input  1  asynchronous, active-low reset.
- i_fifo_q  input  DATA_WIDTH_12  FIFO read data; valid the cycle after rdreq (non-show-ahead FIFO).
- i_fifo_usedw  input  ADDR_WIDTH  FIFO fill level.
- o_fifo_rdreq  output  1  FIFO read request.
- o_window  output  WINDOW_SIZE*DATA_WIDTH_12  flattened window; word k at bits [k*12+11:k*12]; k=0 is the first word read.
- o_window_valid  output  1  window is stable and valid.
- i_window_ready  input  1  consumer accepts the window.
- o_window_count  output  16  windows delivered; wraps at 65535 -> 0.
- o_busy  output  1  high when state != IDLE.

Behaviour:
- Reset (reset_fpga=0, async):
  - state=IDLE.
  - o_fifo_rdreq=0, o_window=0, o_window_valid=0, o_window_count=0, o_busy=0.
  - Read and capture counters = 0.
- FSM states: IDLE, READ, DRAIN, HOLD.
- IDLE:
  - If i_fifo_usedw >= WINDOW_SIZE, go to READ next edge; otherwise stay.
  - Never starts a partial burst, so the block cannot underflow the FIFO.
- READ:
  - o_fifo_rdreq=1 (decoded combinationally from state) for exactly WINDOW_SIZE consecutive cycles, counted by rd_cnt 0..WINDOW_SIZE-1.
  - At rd_cnt==WINDOW_SIZE-1, go to DRAIN.
  - i_fifo_usedw is ignored while in READ.
- Capture:
  - rd_d1 = registered rdreq.
  - On each edge with rd_d1=1, i_fifo_q is written to window word cap_cnt, then cap_cnt increments.
  - cap_cnt clears when the window is accepted.
- DRAIN:
  - One cycle; the last word is captured at this edge.
  - Next state HOLD; o_window_valid is registered to 1 on this edge.
- HOLD:
  - o_window and o_window_valid are held stable until i_window_ready=1.
  - On the accepting edge (valid & ready): o_window_valid goes to 0, o_window_count increments, state goes to IDLE.
  - o_window keeps its last value after acceptance (not cleared).
- Latency:
  - Usedw condition met at edge T: rdreq is high for cycles T+1..T+WINDOW_SIZE.
  - o_window_valid is high from T+WINDOW_SIZE+2.
  - Minimum window period is WINDOW_SIZE+3 cycles.
- i_window_ready:
  - Ignored outside HOLD.
  - If held permanently high, the window is accepted the first cycle valid is seen.
- Full/empty:
  - FIFO full is the writer's concern.
  - usedw == WINDOW_SIZE-1 keeps the block in IDLE indefinitely.
  - usedw == WINDOW_SIZE starts a burst.
- Reset mid-burst aborts with all outputs cleared. The partially consumed FIFO window is not recovered; the system flushes the FIFO on the same reset.

Optional Feature:
- Macro WINDOW_CHECKSUM_EN.
- Defined:
  - Adds output o_window_sum, width DATA_WIDTH_12+4, unsigned.
  - Holds the sum of all WINDOW_SIZE captured words, accumulated during capture and cleared at burst start.
  - Valid coincident with o_window_valid; reset value 0.
- Undefined: port and accumulator are absent; all other behaviour is identical.

Decomposition:
- Shared package integral_pkg holds:
  - constants DATA_WIDTH_12, INTEGRAL_WIDTH, INTEGRAL_HEIGHT, WINDOW_SIZE;
  - FSM state enum typedef window_rd_state_t {IDLE, READ, DRAIN, HOLD};
  - typedef integral_word_t (logic [11:0]).
- One natural sub-module: integral_window_capture, which holds the capture counter, word register bank and optional sum. Driven by rd_d1/i_fifo_q; cleared on accept.

Test Plan:
- usedw=9, q sequence 0x001..0x009, ready=1 -> rdreq high for exactly 9 cycles; valid asserts 11 cycles after usedw sampled; o_window word0=0x001, word8=0x009; count=1.
- usedw=8 held for 50 cycles -> rdreq never asserts, valid stays 0, busy=0.
- Window loaded, ready=0 for 20 cycles then 1 -> o_window stable across all 20 cycles; a single count increment; valid drops the cycle after the accept edge.
- usedw=27, ready=1 -> three back-to-back windows with a 12-cycle period; count=3; no rdreq pulses beyond 27.
- reset_fpga low during READ cycle 4 -> all outputs 0 immediately (async, no clock edge); after release with usedw>=9, a clean new burst of exactly 9 reads.
- WINDOW_CHECKSUM_EN defined, nine words of 0xFFF -> o_window_sum=0x8FF7 with no overflow; count preset to 65535 then one window accepted -> count wraps to 0.

Source files
------------

// File: rtl/integral_pkg.sv
// Shared constants and types for the integral-image window reader.
// The window is INTEGRAL_WIDTH x INTEGRAL_HEIGHT words of DATA_WIDTH_12 bits each.
package integral_pkg;
  localparam int ADDR_WIDTH      = 10;
  localparam int DATA_WIDTH_12   = 12;
  localparam int INTEGRAL_WIDTH  = 3;
  localparam int INTEGRAL_HEIGHT = 3;
  localparam int WINDOW_SIZE     = INTEGRAL_WIDTH * INTEGRAL_HEIGHT;
  localparam int WINDOW_BITS     = WINDOW_SIZE * DATA_WIDTH_12;
  localparam int CNT_WIDTH       = $clog2(WINDOW_SIZE + 1);
  localparam int SUM_WIDTH       = DATA_WIDTH_12 + 4;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, HOLD} window_rd_state_t;
  typedef logic [DATA_WIDTH_12-1:0] integral_word_t;
  typedef logic [CNT_WIDTH-1:0]     win_cnt_t;
  typedef logic [SUM_WIDTH-1:0]     win_sum_t;
endpackage

// File: rtl/integral_window_reader_if.sv
// FIFO read port plus window valid/ready bus; master = reader, slave = FIFO/consumer side.
// WINDOW_CHECKSUM_EN adds o_window_sum.
interface integral_window_reader_if;
  import integral_pkg::*;

  integral_word_t          i_fifo_q;
  logic [ADDR_WIDTH-1:0]   i_fifo_usedw;
  logic                    o_fifo_rdreq;
  logic [WINDOW_BITS-1:0]  o_window;
  logic                    o_window_valid;
  logic                    i_window_ready;
  logic [15:0]             o_window_count;
  logic                    o_busy;
`ifdef WINDOW_CHECKSUM_EN
  win_sum_t                o_window_sum;
`endif

  modport master (
    input  i_fifo_q, i_fifo_usedw, i_window_ready,
    output o_fifo_rdreq, o_window, o_window_valid, o_window_count, o_busy
`ifdef WINDOW_CHECKSUM_EN
    , output o_window_sum
`endif
  );

  modport slave (
    output i_fifo_q, i_fifo_usedw, i_window_ready,
    input  o_fifo_rdreq, o_window, o_window_valid, o_window_count, o_busy
`ifdef WINDOW_CHECKSUM_EN
    , input o_window_sum
`endif
  );
endinterface

// File: rtl/integral_window_capture.sv
// Word register bank filled in read order from the FIFO data, one word per cap_en edge; held until the next burst.
// WINDOW_CHECKSUM_EN adds a running sum cleared at burst start.
module integral_window_capture
  import integral_pkg::*;
(
  input  logic                   clk_fpga,
  input  logic                   reset_fpga,
  input  logic                   i_cap_en,
  input  logic                   i_clear,
`ifdef WINDOW_CHECKSUM_EN
  input  logic                   i_burst_start,
  output win_sum_t               o_window_sum,
`endif
  input  integral_word_t         i_fifo_q,
  output logic [WINDOW_BITS-1:0] o_window
);
  win_cnt_t       r_cap_cnt;
  integral_word_t r_words [WINDOW_SIZE];

  always_ff @(posedge clk_fpga or negedge reset_fpga) begin
    if (!reset_fpga) begin
      r_cap_cnt <= '0;
      for (int k = 0; k < WINDOW_SIZE; k++) r_words[k] <= '0;
    end else if (i_clear) begin
      r_cap_cnt <= '0;
    end else if (i_cap_en) begin
      for (int k = 0; k < WINDOW_SIZE; k++)
        if (r_cap_cnt == win_cnt_t'(k)) r_words[k] <= i_fifo_q;
      r_cap_cnt <= r_cap_cnt + win_cnt_t'(1);
    end
  end

  for (genvar k = 0; k < WINDOW_SIZE; k++) begin : g_pack
    assign o_window[k*DATA_WIDTH_12 +: DATA_WIDTH_12] = r_words[k];
  end

`ifdef WINDOW_CHECKSUM_EN
  // Four guard bits cover nine full-scale words without overflow.
  win_sum_t r_sum;
  always_ff @(posedge clk_fpga or negedge reset_fpga) begin
    if (!reset_fpga)
      r_sum <= '0;
    else if (i_burst_start)
      r_sum <= '0;
    else if (i_cap_en)
      r_sum <= r_sum + win_sum_t'(i_fifo_q);
  end
  assign o_window_sum = r_sum;
`endif
endmodule

// File: rtl/integral_window_reader.sv
// Drains one WINDOW_SIZE-word burst from a non-show-ahead FIFO into a parallel window; valid WINDOW_SIZE+2 cycles after start.
// Window held until i_window_ready; bursts start only when a full window is buffered. WINDOW_CHECKSUM_EN adds o_window_sum.
module integral_window_reader
  import integral_pkg::*;
(
  input  logic                     clk_fpga,
  input  logic                     reset_fpga,
  integral_window_reader_if.master bus
);
  window_rd_state_t r_state;
  win_cnt_t         r_rd_cnt;
  logic             r_rd_d1;
  logic             r_window_valid;
  logic [15:0]      r_window_count;
  logic             w_start;
  logic             w_accept;

  assign w_start  = (r_state == IDLE) && (bus.i_fifo_usedw >= ADDR_WIDTH'(WINDOW_SIZE));
  assign w_accept = (r_state == HOLD) && r_window_valid && bus.i_window_ready;

  always_ff @(posedge clk_fpga or negedge reset_fpga) begin
    if (!reset_fpga) begin
      r_state        <= IDLE;
      r_rd_cnt       <= '0;
      r_rd_d1        <= 1'b0;
      r_window_valid <= 1'b0;
      r_window_count <= '0;
    end else begin
      // FIFO data lags rdreq by one cycle, so capture follows the delayed request.
      r_rd_d1 <= (r_state == READ);
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state  <= READ;
            r_rd_cnt <= '0;
          end
        end
        READ: begin
          if (r_rd_cnt == win_cnt_t'(WINDOW_SIZE - 1)) begin
            r_state  <= DRAIN;
            r_rd_cnt <= '0;
          end else begin
            r_rd_cnt <= r_rd_cnt + win_cnt_t'(1);
          end
        end
        DRAIN: begin
          r_state        <= HOLD;
          r_window_valid <= 1'b1;
        end
        HOLD: begin
          if (w_accept) begin
            r_state        <= IDLE;
            r_window_valid <= 1'b0;
            r_window_count <= r_window_count + 16'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.o_fifo_rdreq   = (r_state == READ);
  assign bus.o_busy         = (r_state != IDLE);
  assign bus.o_window_valid = r_window_valid;
  assign bus.o_window_count = r_window_count;

  integral_window_capture u_capture (
    .clk_fpga      (clk_fpga),
    .reset_fpga    (reset_fpga),
    .i_cap_en      (r_rd_d1),
    .i_clear       (w_accept),
`ifdef WINDOW_CHECKSUM_EN
    .i_burst_start (w_start),
    .o_window_sum  (bus.o_window_sum),
`endif
    .i_fifo_q      (bus.i_fifo_q),
    .o_window      (bus.o_window)
  );
endmodule

// File: tb/tb_integral_window_reader.sv
// Directed bench: FIFO model feeds the reader, a scoreboard queue holds expected windows,
// and a monitor compares every cycle the window is presented.
module tb_integral_window_reader;
  import integral_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  integral_window_reader_if bus();

  integral_window_reader dut (
    .clk_fpga   (clk),
    .reset_fpga (rst_n),
    .bus        (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int rd_pulses = 0;
  int exp_count = 0;
  int pend_n = 0;
  integral_word_t         fifo_q [$];
  logic [WINDOW_BITS-1:0] exp_q [$];
  logic [WINDOW_BITS-1:0] pend_win = '0;
  logic [WINDOW_BITS-1:0] last_full = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_word(input integral_word_t w);
    fifo_q.push_back(w);
    pend_win[pend_n*DATA_WIDTH_12 +: DATA_WIDTH_12] = w;
    pend_n++;
    if (pend_n == WINDOW_SIZE) begin
      exp_q.push_back(pend_win);
      last_full = pend_win;
      pend_win  = '0;
      pend_n    = 0;
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || bus.o_busy || fifo_q.size() >= WINDOW_SIZE) && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    if (n >= budget) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: timeout after %0d cycles, %0d windows outstanding", name, n, exp_q.size());
    end
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n = 0;
    while (!bus.o_window_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: valid never asserted within %0d cycles", name, budget);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Non-show-ahead FIFO: rdreq sampled at an edge, q and usedw update just after it.
  initial begin
    logic pend;
    bus.i_fifo_q     = '0;
    bus.i_fifo_usedw = '0;
    forever begin
      @(negedge clk);
      pend = bus.o_fifo_rdreq;
      if (pend) rd_pulses++;
      @(posedge clk);
      #1;
      if (pend && fifo_q.size() > 0) bus.i_fifo_q = fifo_q.pop_front();
      bus.i_fifo_usedw = ADDR_WIDTH'(fifo_q.size());
    end
  end

  // Scoreboard monitor.
  initial forever begin
    @(negedge clk);
    if (rst_n && bus.o_window_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_window: got %0h with no window expected", bus.o_window);
      end else begin
        check("window", bus.o_window, exp_q[0]);
        check("count_at_valid", bus.o_window_count, exp_count);
`ifdef WINDOW_CHECKSUM_EN
        begin
          int s;
          logic [WINDOW_BITS-1:0] ew;
          ew = exp_q[0];
          s = 0;
          for (int k = 0; k < WINDOW_SIZE; k++) s += int'(ew[k*DATA_WIDTH_12 +: DATA_WIDTH_12]);
          check("window_sum", bus.o_window_sum, s);
        end
`endif
        if (bus.i_window_ready) begin
          void'(exp_q.pop_front());
          exp_count = (exp_count + 1) & 16'hFFFF;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_u, t_v, p0, c0, bad, nv;
    int tv [3];
    logic prev_v;
    logic [WINDOW_BITS-1:0] w_exp;

    bus.i_window_ready = 1'b1;
    #22 rst_n = 1'b1;
    @(negedge clk);
    check("rst_rdreq", bus.o_fifo_rdreq, 0);
    check("rst_valid", bus.o_window_valid, 0);
    check("rst_count", bus.o_window_count, 0);
    check("rst_busy", bus.o_busy, 0);
    check("rst_window", bus.o_window, 0);

    // Single window, ready high: latency and read count.
    p0 = rd_pulses; t_u = -1; t_v = -1;
    for (int k = 1; k <= 9; k++) push_word(integral_word_t'(k));
    for (int n = 0; n < 40 && t_v < 0; n++) begin
      @(negedge clk);
      if (t_u < 0 && bus.i_fifo_usedw >= ADDR_WIDTH'(WINDOW_SIZE)) t_u = cyc;
      if (bus.o_window_valid) t_v = cyc;
    end
    check("latency_usedw_to_valid", t_v - t_u, 11);
    wait_idle("win1", 40);
    check("win1_rdreq_pulses", rd_pulses - p0, 9);
    check("win1_word0", bus.o_window[11:0], 12'h001);
    check("win1_word8", bus.o_window[107:96], 12'h009);
    check("win1_count", bus.o_window_count, 1);

    // usedw one short of a window: must stay idle.
    p0 = rd_pulses; bad = 0;
    for (int k = 0; k < 8; k++) push_word(integral_word_t'(12'h100 + k));
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.o_busy || bus.o_window_valid || bus.o_fifo_rdreq) bad++;
    end
    check("usedw8_idle_cycles_busy", bad, 0);
    check("usedw8_rdreq_pulses", rd_pulses - p0, 0);
    push_word(12'h108);
    wait_idle("usedw9", 40);
    check("usedw9_rdreq_pulses", rd_pulses - p0, 9);

    // Backpressure: hold for 20 cycles, then accept once.
    bus.i_window_ready = 1'b0;
    c0 = exp_count;
    for (int k = 0; k < 9; k++) push_word(integral_word_t'(12'h2A0 + k));
    w_exp = last_full;
    wait_valid("hold_valid", 30);
    nv = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.o_window_valid) nv++;
    end
    check("hold_valid_cycles", nv, 20);
    check("hold_count_unchanged", bus.o_window_count, c0);
    @(posedge clk);
    #1 bus.i_window_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("hold_valid_dropped", bus.o_window_valid, 0);
    check("hold_count_incr", bus.o_window_count, c0 + 1);
    check("hold_window_kept", bus.o_window, w_exp);
    wait_idle("hold", 20);

    // Three back-to-back windows.
    p0 = rd_pulses; c0 = exp_count; nv = 0; prev_v = 1'b0;
    for (int k = 0; k < 27; k++) push_word(integral_word_t'(12'h300 + k));
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (bus.o_window_valid && !prev_v && nv < 3) begin
        tv[nv] = cyc;
        nv++;
      end
      prev_v = bus.o_window_valid;
    end
    check("b2b_windows_seen", nv, 3);
    check("b2b_period_1", tv[1] - tv[0], 12);
    check("b2b_period_2", tv[2] - tv[1], 12);
    check("b2b_rdreq_pulses", rd_pulses - p0, 27);
    check("b2b_count", bus.o_window_count, c0 + 3);

    // Asynchronous reset in the fourth READ cycle.
    for (int k = 0; k < 9; k++) push_word(integral_word_t'(12'h400 + k));
    bad = 0;
    while (!bus.o_fifo_rdreq && bad < 20) begin
      @(negedge clk);
      bad++;
    end
    check("abort_burst_started", bus.o_fifo_rdreq, 1);
    repeat (3) @(negedge clk);
    #2;
    fifo_q.delete();
    exp_q.delete();
    pend_n = 0;
    pend_win = '0;
    exp_count = 0;
    rst_n = 1'b0;
    #1;
    check("abort_rdreq", bus.o_fifo_rdreq, 0);
    check("abort_valid", bus.o_window_valid, 0);
    check("abort_busy", bus.o_busy, 0);
    check("abort_count", bus.o_window_count, 0);
    check("abort_window", bus.o_window, 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    p0 = rd_pulses;
    for (int k = 0; k < 9; k++) push_word(integral_word_t'(12'h500 + k));
    wait_idle("post_reset", 40);
    check("post_reset_rdreq_pulses", rd_pulses - p0, 9);
    check("post_reset_count", bus.o_window_count, 1);

`ifdef WINDOW_CHECKSUM_EN
    bus.i_window_ready = 1'b0;
    for (int k = 0; k < 9; k++) push_word(12'hFFF);
    wait_valid("sum_valid", 30);
    check("sum_all_fff", bus.o_window_sum, 16'h8FF7);
    @(posedge clk);
    #1 bus.i_window_ready = 1'b1;
    wait_idle("sum", 20);
`endif

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
